jtvigil_prog: RTL and testbench
===============================

Name: jtvigil_prog

Overview:
ROM download front-end for the Vigilante core. It converts the byte-wide ioctl download stream into SDRAM programming writes, driving prog_addr, prog_data, prog_mask, prog_ba and prog_we into the core's SDRAM block. It selects the bank by address region, swizzles graphics addresses so 32-bit fetches return contiguous pixel data, and buffers writes across the prog_we/prog_ack handshake. It also owns dwnld_busy.

Parameters:
BA1_START, 25'h40000, first ioctl byte of bank 1 (sound CPU ROM + PCM ROM)
BA2_START, 25'h60000, first ioctl byte of bank 2 (scroll 1 + scroll 2 graphics)
BA3_START, 25'hE0000, first ioctl byte of bank 3 (object graphics)
ROM_END, 25'h1E0000, first byte past the ROM image; bytes at or above it are discarded

Ports:
clk  in  1  SDRAM-domain clock; the only clock
rst  in  1  synchronous, active-high reset
downloading  in  1  download window active
ioctl_addr  in  25  byte address of the incoming byte
ioctl_dout  in  8  incoming byte
ioctl_wr  in  1  one-cycle strobe, byte valid
prog_addr  out  22  16-bit word address within the selected bank
prog_data  out  16  {byte,byte}, written byte replicated on both lanes
prog_mask  out  2  active-low byte enable; 2'b10 = low byte, 2'b01 = high byte
prog_ba  out  2  target bank
prog_we  out  1  write request, held until acknowledged
prog_ack  in  1  SDRAM accepted the current write
dwnld_busy  out  1  download or pending writes in progress
overflow  out  1  sticky: a byte was dropped because the buffer was full

Behaviour:
- Reset: all outputs 0 except prog_mask=2'b11. Buffer emptied, overflow cleared. A reset mid-transfer abandons the pending write.
- Region decode on ioctl_wr:
  - ba=0 when addr<BA1_START
  - ba=1 when addr<BA2_START
  - ba=2 when addr<BA3_START
  - ba=3 when addr<ROM_END
  - off = addr - bank start.
  - addr>=ROM_END: byte ignored, no buffer entry, no overflow.
- GFX swizzle (ba 2 and 3 only): off'[5:2] = {off[4:2], off[5]}; all other bits unchanged. Banks 0 and 1 use off'=off.
- Entry fields:
  - prog_addr = off'[22:1]
  - prog_mask = off'[0] ? 2'b01 : 2'b10
  - prog_data = {dout,dout}
- Buffer: 2-entry FIFO.
  - Push occurs in the cycle after ioctl_wr (one register stage for decode).
  - A push while full is dropped and sets overflow, unless a pop happens in the same cycle, in which case the push is accepted.
- Write FSM, states IDLE, WRITE, GAP:
  - IDLE -> WRITE when the FIFO is non-empty. Outputs are loaded from the head and prog_we=1 on the next cycle.
  - WRITE: outputs are held stable. When prog_ack=1, pop the head, set prog_we=0 and go to GAP.
  - GAP lasts exactly 1 cycle, then goes to IDLE. This guarantees prog_we is low for at least one cycle between writes.
  - Minimum spacing between writes: ack -> next prog_we rise = 2 cycles.
- dwnld_busy = downloading | FIFO non-empty | state!=IDLE. It falls in the first cycle that all three are clear after downloading drops.
- overflow clears on the rising edge of downloading.
- ioctl_wr while downloading=0 is ignored.

Decomposition:
- Package jtvigil_prog_pkg holds the bank-start localparams shared with the SDRAM block, the FSM state encoding, and the FIFO entry struct: {ba[1:0], addr[21:0], mask[1:0], data[7:0]}.
- One natural sub-module, jtvigil_prog_fifo: 2-deep, 34-bit entries, push/pop/full/empty, simultaneous push+pop when full allowed.

Test Plan:
- Bank 0 high byte: downloading=1, byte 0xA5 at 25'h3 -> prog_ba=0, prog_addr=1, prog_mask=2'b01, prog_data=16'hA5A5; prog_we held until prog_ack, then low.
- Bank 1 low byte: byte at 25'h40000 -> prog_ba=1, prog_addr=0, prog_mask=2'b10; byte at 25'h5FFFF -> prog_ba=1, prog_addr=22'h FFFF, prog_mask=2'b01.
- GFX swizzle: byte at BA2_START+6'h20 -> prog_ba=2, prog_addr=2, prog_mask=2'b10; byte at BA3_START+6'h04 -> prog_ba=3, prog_addr=4.
- Backpressure: 3 ioctl_wr strobes with prog_ack held low -> first 2 are buffered and written in order once acks return, third is dropped, overflow=1. A new downloading rise clears overflow.
- End of download: byte at 25'h1E0000 -> no write. downloading falls with 1 entry pending -> dwnld_busy stays 1 until that entry's ack plus the GAP cycle, then 0.
- Reset mid-write: rst asserted while prog_we=1 -> next cycle prog_we=0, FIFO empty, dwnld_busy follows downloading only.

Source files
------------

// File: rtl/jtvigil_prog_pkg.sv
// Shared constants, FSM encoding and buffered-write entry layout for the
// Vigilante ROM download front-end.
package jtvigil_prog_pkg;

    localparam logic [24:0] BA1_START = 25'h40000;
    localparam logic [24:0] BA2_START = 25'h60000;
    localparam logic [24:0] BA3_START = 25'hE0000;
    localparam logic [24:0] ROM_END   = 25'h1E0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0]  ba;
        logic [21:0] addr;
        logic [1:0]  mask;
        logic [7:0]  data;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    // Graphics banks move bit 5 down to bit 2 so a 32-bit fetch covers contiguous pixels.
    function automatic logic [22:0] gfx_swizzle(input logic [22:0] off);
        return {off[22:6], off[4:2], off[5], off[1:0]};
    endfunction

endpackage

// File: rtl/jtvigil_prog_fifo.sv
// Two-entry FIFO for pending SDRAM writes; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module jtvigil_prog_fifo
    import jtvigil_prog_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_push,
    input  logic [ENTRY_W-1:0] i_din,
    input  logic               i_pop,
    output logic [ENTRY_W-1:0] o_dout,
    output logic               o_full,
    output logic               o_empty
);

    logic [ENTRY_W-1:0] r_mem [2];
    logic               r_wptr;
    logic               r_rptr;
    logic [1:0]         r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign o_full    = (r_count == 2'd2);
    assign o_empty   = (r_count == 2'd0);
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_dout    = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_do_push) r_wptr <= ~r_wptr;
            if (w_do_pop)  r_rptr <= ~r_rptr;
            r_count <= r_count + {1'b0, w_do_push} - {1'b0, w_do_pop};
        end
    end

endmodule

// File: rtl/jtvigil_prog.sv
// Converts the byte-wide ioctl download stream into banked SDRAM programming
// writes with a prog_we/prog_ack handshake and a two-entry write buffer.
module jtvigil_prog
    import jtvigil_prog_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        downloading,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic [21:0] prog_addr,
    output logic [15:0] prog_data,
    output logic [1:0]  prog_mask,
    output logic [1:0]  prog_ba,
    output logic        prog_we,
    input  logic        prog_ack,
    output logic        dwnld_busy,
    output logic        overflow
);

    logic [1:0]  w_ba;
    logic [22:0] w_off;
    logic [22:0] w_offs;
    entry_t      w_entry;
    entry_t      w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_drop;

    logic        r_dec_valid;
    entry_t      r_dec_entry;
    state_t      r_state;
    logic [21:0] r_addr;
    logic [15:0] r_data;
    logic [1:0]  r_mask;
    logic [1:0]  r_ba;
    logic        r_we;
    logic        r_overflow;
    logic        r_dl_prev;

    always_comb begin
        w_ba  = 2'd0;
        w_off = ioctl_addr[22:0];
        if (ioctl_addr < BA1_START) begin
            w_ba  = 2'd0;
            w_off = ioctl_addr[22:0];
        end else if (ioctl_addr < BA2_START) begin
            w_ba  = 2'd1;
            w_off = 23'(ioctl_addr - BA1_START);
        end else if (ioctl_addr < BA3_START) begin
            w_ba  = 2'd2;
            w_off = 23'(ioctl_addr - BA2_START);
        end else begin
            w_ba  = 2'd3;
            w_off = 23'(ioctl_addr - BA3_START);
        end
        w_offs       = w_ba[1] ? gfx_swizzle(w_off) : w_off;
        w_entry.ba   = w_ba;
        w_entry.addr = w_offs[22:1];
        w_entry.mask = w_offs[0] ? 2'b01 : 2'b10;
        w_entry.data = ioctl_dout;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dec_valid <= 1'b0;
            r_dec_entry <= '0;
        end else begin
            r_dec_valid <= ioctl_wr & downloading & (ioctl_addr < ROM_END);
            r_dec_entry <= w_entry;
        end
    end

    assign w_pop  = (r_state == ST_WRITE) & prog_ack;
    assign w_drop = r_dec_valid & w_full & ~w_pop;

    jtvigil_prog_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_dec_valid),
        .i_din   (r_dec_entry),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mask  <= 2'b11;
            r_ba    <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_empty) begin
                        r_addr  <= w_head.addr;
                        r_data  <= {w_head.data, w_head.data};
                        r_mask  <= w_head.mask;
                        r_ba    <= w_head.ba;
                        r_we    <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (prog_ack) begin
                        r_we    <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_dl_prev  <= 1'b0;
        end else begin
            r_dl_prev <= downloading;
            if (downloading && !r_dl_prev) begin
                r_overflow <= 1'b0;
            end else if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign prog_addr = r_addr;
    assign prog_data = r_data;
    assign prog_mask = r_mask;
    assign prog_ba   = r_ba;
    assign prog_we   = r_we;
    assign overflow  = r_overflow;
    // The decode stage also counts, so a byte strobed just as downloading drops keeps busy high.
    assign dwnld_busy = downloading | ~w_empty | (r_state != ST_IDLE) | r_dec_valid;

endmodule

// File: tb/tb_jtvigil_prog.sv
// Directed bench for jtvigil_prog: bank decode, graphics swizzle,
// backpressure/overflow, end of download and reset during a write.
module tb_jtvigil_prog;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        downloading = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_dout = '0;
    logic        ioctl_wr = 1'b0;
    logic        prog_ack = 1'b0;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask;
    logic [1:0]  prog_ba;
    logic        prog_we;
    logic        dwnld_busy;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    jtvigil_prog dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .ioctl_addr  (ioctl_addr),
        .ioctl_dout  (ioctl_dout),
        .ioctl_wr    (ioctl_wr),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .prog_ba     (prog_ba),
        .prog_we     (prog_we),
        .prog_ack    (prog_ack),
        .dwnld_busy  (dwnld_busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_we(input string tag);
        int n = 0;
        while (!prog_we && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_we_rise"}, {31'd0, prog_we}, 32'd1);
    endtask

    task automatic ack_write(input string tag);
        prog_ack = 1'b1;
        tick();
        prog_ack = 1'b0;
        check({tag, "_we_low_after_ack"}, {31'd0, prog_we}, 32'd0);
    endtask

    task automatic expect_fields(input string tag, input logic [1:0] eba,
                                 input logic [21:0] eaddr, input logic [1:0] emask,
                                 input logic [7:0] ed);
        check({tag, "_ba"},   {30'd0, prog_ba},   {30'd0, eba});
        check({tag, "_addr"}, {10'd0, prog_addr}, {10'd0, eaddr});
        check({tag, "_mask"}, {30'd0, prog_mask}, {30'd0, emask});
        check({tag, "_data"}, {16'd0, prog_data}, {16'd0, ed, ed});
        $display("write %s: ba=%0d addr=%h mask=%b data=%h", tag, prog_ba, prog_addr, prog_mask, prog_data);
    endtask

    task automatic write_expect(input string tag, input logic [24:0] a, input logic [7:0] d,
                                input logic [1:0] eba, input logic [21:0] eaddr,
                                input logic [1:0] emask);
        send_byte(a, d);
        wait_we(tag);
        expect_fields(tag, eba, eaddr, emask, d);
        repeat (3) tick();
        check({tag, "_we_held"}, {31'd0, prog_we}, 32'd1);
        expect_fields({tag, "_held"}, eba, eaddr, emask, d);
        ack_write(tag);
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_we",       {31'd0, prog_we},    32'd0);
        check("rst_mask",     {30'd0, prog_mask},  32'd3);
        check("rst_addr",     {10'd0, prog_addr},  32'd0);
        check("rst_data",     {16'd0, prog_data},  32'd0);
        check("rst_ba",       {30'd0, prog_ba},    32'd0);
        check("rst_overflow", {31'd0, overflow},   32'd0);
        check("rst_busy",     {31'd0, dwnld_busy}, 32'd0);
        rst = 1'b0;
        tick();

        // Strobes outside the download window are ignored
        send_byte(25'h30, 8'h12);
        repeat (5) tick();
        check("idle_wr_we",   {31'd0, prog_we},    32'd0);
        check("idle_wr_busy", {31'd0, dwnld_busy}, 32'd0);

        downloading = 1'b1;
        tick();
        check("dl_busy", {31'd0, dwnld_busy}, 32'd1);

        // Bank decode and graphics swizzle
        write_expect("b0_hi",   25'h3,       8'hA5, 2'd0, 22'h1,    2'b01);
        write_expect("b1_lo",   25'h40000,   8'h11, 2'd1, 22'h0,    2'b10);
        write_expect("b1_top",  25'h5FFFF,   8'h22, 2'd1, 22'hFFFF, 2'b01);
        write_expect("b2_swz",  25'h60020,   8'h33, 2'd2, 22'h2,    2'b10);
        write_expect("b3_swz",  25'hE0004,   8'h44, 2'd3, 22'h4,    2'b10);
        write_expect("b3_last", 25'h1DFFFF,  8'h55, 2'd3, 22'h7FFFF, 2'b01);

        // Backpressure: third strobe is dropped and flags overflow
        send_byte(25'h10, 8'h01);
        send_byte(25'h11, 8'h02);
        send_byte(25'h12, 8'h03);
        repeat (4) tick();
        check("bp_overflow", {31'd0, overflow}, 32'd1);
        check("bp_we",       {31'd0, prog_we},  32'd1);
        expect_fields("bp_first", 2'd0, 22'h8, 2'b10, 8'h01);
        ack_write("bp_first");
        tick();
        check("bp_gap_we", {31'd0, prog_we}, 32'd0);
        tick();
        check("bp_second_rise", {31'd0, prog_we}, 32'd1);
        expect_fields("bp_second", 2'd0, 22'h8, 2'b01, 8'h02);
        ack_write("bp_second");
        repeat (6) tick();
        check("bp_third_dropped", {31'd0, prog_we}, 32'd0);
        downloading = 1'b0;
        tick();
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        downloading = 1'b1;
        tick();
        check("ovf_clear_on_rise", {31'd0, overflow}, 32'd0);

        // End of download: out-of-range byte discarded, busy covers pending write
        send_byte(25'h1E0000, 8'hFF);
        repeat (6) tick();
        check("rom_end_no_write", {31'd0, prog_we},    32'd0);
        check("rom_end_no_ovf",   {31'd0, overflow},   32'd0);
        send_byte(25'h20, 8'h77);
        downloading = 1'b0;
        tick();
        check("end_busy_pending", {31'd0, dwnld_busy}, 32'd1);
        wait_we("end");
        expect_fields("end", 2'd0, 22'h10, 2'b10, 8'h77);
        check("end_busy_write", {31'd0, dwnld_busy}, 32'd1);
        ack_write("end");
        check("end_busy_gap", {31'd0, dwnld_busy}, 32'd1);
        tick();
        check("end_busy_clear", {31'd0, dwnld_busy}, 32'd0);

        // Reset in the middle of a write abandons it
        downloading = 1'b1;
        tick();
        send_byte(25'h40, 8'h34);
        wait_we("rstw");
        expect_fields("rstw", 2'd0, 22'h20, 2'b10, 8'h34);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstw_we",   {31'd0, prog_we},    32'd0);
        check("rstw_mask", {30'd0, prog_mask},  32'd3);
        check("rstw_busy", {31'd0, dwnld_busy}, 32'd1);
        downloading = 1'b0;
        tick();
        check("rstw_busy_follows", {31'd0, dwnld_busy}, 32'd0);
        repeat (5) tick();
        check("rstw_fifo_empty", {31'd0, prog_we}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
